input_packet_buffer: RTL and testbench

//  Host-side ingress FIFO for the RANC grid. Host writes spike packets (dx, dy, axon, tick).
//  The grid's core 0 west router drains them through the grid's packet_in, input_buffer_empty
//  and ren_to_input_buffer signals.

---
 rtl/input_packet_buffer.sv | 88 ++++++++
 tb/tb_input_packet_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/input_packet_buffer.sv
// Host-side ingress FIFO for the RANC grid: the host pushes spike packets and the core 0
// west router drains them first-word-fall-through, with occupancy and sticky error flags.
module input_packet_buffer #(
   parameter int PACKET_WIDTH = 30,
   parameter int DEPTH        = 64,
   parameter int ALMOST_FULL  = 4,
   localparam int CW          = $clog2(DEPTH + 1),
   localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wen,
   input  logic [PACKET_WIDTH-1:0] din,
   output logic                    full,
   output logic                    almost_full,
   input  logic                    ren,
   output logic [PACKET_WIDTH-1:0] packet_out,
   output logic                    empty,
   output logic [CW-1:0]           count,
   output logic                    overflow,
   output logic                    underflow
);

   logic [PACKET_WIDTH-1:0] mem [0:DEPTH-1];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW-1:0]           wr_ptr_next;
   logic [AW-1:0]           rd_ptr_next;
   logic [CW-1:0]           count_next;
   logic [31:0]             free_slots;
   logic                    rd_ok;
   logic                    wr_ok;

   // Flags come only from the registered count, so wen/ren never reach them combinationally.
   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign free_slots  = 32'(DEPTH) - 32'(count);
   assign almost_full = (free_slots <= 32'(ALMOST_FULL));

   assign packet_out  = empty ? '0 : mem[rd_ptr];

   // A pop on a full cycle frees the slot that a same-cycle write then takes.
   assign rd_ok = ren & ~empty;
   assign wr_ok = wen & (~full | rd_ok);

   assign wr_ptr_next = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
   assign rd_ptr_next = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr_next;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr_next;
         end
         count <= count_next;
         if (wen && !wr_ok) begin
            overflow <= 1'b1;
         end
         if (ren && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_input_packet_buffer.sv
// Scoreboard bench for input_packet_buffer: a reference queue predicts every head packet,
// flag and count, and popped packets are compared against the queue front.
module tb_input_packet_buffer;

   localparam int PW    = 30;
   localparam int DEPTH = 64;
   localparam int AF    = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst;
   logic          wen;
   logic [PW-1:0] din;
   logic          full;
   logic          almost_full;
   logic          ren;
   logic [PW-1:0] packet_out;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   logic [PW-1:0] sb_queue [$];
   logic          model_overflow;
   logic          model_underflow;
   logic [PW-1:0] last_popped;
   int            tests_run;
   int            tests_failed;

   input_packet_buffer #(
      .PACKET_WIDTH(PW),
      .DEPTH(DEPTH),
      .ALMOST_FULL(AF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wen(wen),
      .din(din),
      .full(full),
      .almost_full(almost_full),
      .ren(ren),
      .packet_out(packet_out),
      .empty(empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Compares every visible output against the reference queue and sticky error model.
   task automatic checkState(input string tag);
      int n;
      n = sb_queue.size();
      checkOutput({tag, ".count"}, 32'(count), 32'(n));
      checkOutput({tag, ".empty"}, 32'(empty), 32'(n == 0));
      checkOutput({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'((DEPTH - n) <= AF));
      checkOutput({tag, ".packet_out"}, 32'(packet_out), (n == 0) ? 32'd0 : 32'(sb_queue[0]));
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'(model_overflow));
      checkOutput({tag, ".underflow"}, 32'(underflow), 32'(model_underflow));
   endtask

   // Drives one cycle from a negedge; a pop is checked against the queue front before the edge,
   // the way the grid samples packet_out in the cycle it asserts ren.
   task automatic applyStimulus(input logic w, input logic [PW-1:0] d, input logic r, input string tag);
      logic rd_ok;
      logic wr_ok;
      logic [PW-1:0] head;
      wen = w;
      din = d;
      ren = r;
      rd_ok = r && (sb_queue.size() > 0);
      wr_ok = w && ((sb_queue.size() < DEPTH) || rd_ok);
      if (r && sb_queue.size() == 0) model_underflow = 1'b1;
      if (w && !wr_ok) model_overflow = 1'b1;
      if (rd_ok) begin
         head = sb_queue.pop_front();
         last_popped = head;
         checkOutput({tag, ".pop_data"}, 32'(packet_out), 32'(head));
      end
      if (wr_ok) sb_queue.push_back(d);
      @(posedge clk);
      @(negedge clk);
      wen = 1'b0;
      ren = 1'b0;
      din = '0;
      checkState(tag);
   endtask

   task automatic resetModel();
      sb_queue.delete();
      model_overflow  = 1'b0;
      model_underflow = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] pkt_b;
      tests_run    = 0;
      tests_failed = 0;
      last_popped  = '0;
      wen = 1'b0;
      ren = 1'b0;
      din = '0;
      rst = 1'b1;
      resetModel();
      repeat (2) @(negedge clk);
      checkState("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single write into empty FIFO");
      applyStimulus(1'b1, 30'h1234567, 1'b0, "first_write");
      checkOutput("first_write.head_is_A", 32'(packet_out), 32'h1234567);

      $display("[TB] fill to full and overflow");
      for (int i = 1; i < DEPTH; i++) begin
         applyStimulus(1'b1, PW'(30'h0100000 + i), 1'b0, "fill");
      end
      checkOutput("fill.full", 32'(full), 32'd1);
      applyStimulus(1'b1, 30'h3ABCDEF, 1'b0, "overflow_write");
      checkOutput("overflow_write.count", 32'(count), 32'(DEPTH));
      checkOutput("overflow_write.flag", 32'(overflow), 32'd1);

      $display("[TB] push and pop while full, then drain");
      pkt_b = 30'h2BBBBBB;
      applyStimulus(1'b1, pkt_b, 1'b1, "full_wr_rd");
      checkOutput("full_wr_rd.full", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "drain");
      end
      checkOutput("drain.b_last", 32'(last_popped), 32'(pkt_b));

      $display("[TB] underflow and empty write+read");
      applyStimulus(1'b0, '0, 1'b1, "underflow_read");
      checkOutput("underflow_read.flag", 32'(underflow), 32'd1);
      applyStimulus(1'b1, 30'h0C0FFEE, 1'b1, "empty_wr_rd");
      checkOutput("empty_wr_rd.head", 32'(packet_out), 32'h0C0FFEE);

      $display("[TB] random push/pop with wrap-around");
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), PW'($urandom), 1'($urandom_range(0, 1)), "random");
      end

      $display("[TB] asynchronous reset mid-stream");
      while (sb_queue.size() > 10) applyStimulus(1'b0, '0, 1'b1, "trim");
      while (sb_queue.size() < 10) applyStimulus(1'b1, PW'($urandom), 1'b0, "top_up");
      applyStimulus(1'b1, 30'h1111111, 1'b1, "pre_reset");
      #2;
      rst = 1'b1;
      resetModel();
      #1;
      checkOutput("async_reset.empty", 32'(empty), 32'd1);
      checkOutput("async_reset.count", 32'(count), 32'd0);
      checkOutput("async_reset.overflow", 32'(overflow), 32'd0);
      checkOutput("async_reset.underflow", 32'(underflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkState("post_reset_idle");
      applyStimulus(1'b1, 30'h0ABCDEF, 1'b0, "post_reset_write");
      applyStimulus(1'b0, '0, 1'b1, "post_reset_read");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
